// File: rtl/iq_pkg.sv
// Shared types and saturating-add helpers for the windowed I/Q integrator.
package iq_pkg;

  localparam int unsigned LANES_DEFAULT    = 5;
  localparam int unsigned SAMPLE_W_DEFAULT = 16;
  localparam int unsigned SAT_W            = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SKIP  = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } integ_state_t;

  // Largest positive value of a w-bit two's complement number, held in SAT_W bits.
  function automatic logic signed [SAT_W-1:0] sat_max(input int unsigned w);
    logic signed [SAT_W-1:0] one;
    one = SAT_W'(1);
    return (one <<< (w - 1)) - one;
  endfunction

  // a + b clamped to the w-bit signed range (w <= 62, a and b already in range).
  function automatic logic [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] a,
                                               input logic signed [SAT_W-1:0] b,
                                               input int unsigned w);
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = a + b;
    hi  = sat_max(w);
    lo  = -hi - SAT_W'(1);
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return sum;
  endfunction

  // High when a + b falls outside the w-bit signed range.
  function automatic logic sat_ovf(input logic signed [SAT_W-1:0] a,
                                   input logic signed [SAT_W-1:0] b,
                                   input int unsigned w);
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = a + b;
    hi  = sat_max(w);
    lo  = -hi - SAT_W'(1);
    return (sum > hi) || (sum < lo);
  endfunction

endpackage

// File: rtl/lane_sum_tree.sv
// Registered signed reduction of LANES packed sample lanes; one cycle of latency.
module lane_sum_tree #(
  parameter int unsigned LANES    = 5,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned SUM_W    = SAMPLE_W + $clog2(LANES)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [LANES*SAMPLE_W-1:0]   lanes_i,
  output logic signed [SUM_W-1:0]     sum_o
);

  logic signed [SUM_W-1:0]    sum_d;
  logic signed [SUM_W-1:0]    sum_q;
  logic signed [SAMPLE_W-1:0] lane;

  always_comb begin
    sum_d = '0;
    lane  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane  = lanes_i[l*SAMPLE_W +: SAMPLE_W];
      sum_d = sum_d + SUM_W'(lane);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/iq_window_integrator.sv
// Windowed I/Q integrator: skip N valid beats, saturating-sum the next M beats,
// shift and deliver the result over a valid/ready handshake.
module iq_window_integrator
  import iq_pkg::*;
#(
  parameter int unsigned LANES    = LANES_DEFAULT,
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned LEN_W    = 11
) (
  input  logic                        clk100,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [LEN_W-1:0]            skip_cycles,
  input  logic [LEN_W-1:0]            sample_length,
  input  logic [4:0]                  out_shift,
  input  logic                        data_valid,
  input  logic [LANES*SAMPLE_W-1:0]   data_i,
  input  logic [LANES*SAMPLE_W-1:0]   data_q,
  output logic                        busy,
  output logic                        iq_valid,
  input  logic                        iq_ready,
  output logic signed [ACC_W-1:0]     i_val,
  output logic signed [ACC_W-1:0]     q_val,
  output logic                        sat
);

  localparam int unsigned SUM_W = SAMPLE_W + $clog2(LANES);

  integ_state_t            state_q, state_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [LEN_W-1:0]        skip_q, skip_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [4:0]              shift_q, shift_d;
  logic                    drain_q, drain_d;
  logic                    add_q, add_d;
  logic signed [ACC_W-1:0] acci_q, acci_d;
  logic signed [ACC_W-1:0] accq_q, accq_d;
  logic signed [ACC_W-1:0] i_val_q, i_val_d;
  logic signed [ACC_W-1:0] q_val_q, q_val_d;
  logic                    win_sat_q, win_sat_d;
  logic                    sat_q, sat_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic signed [SUM_W-1:0] sum_ich;
  logic signed [SUM_W-1:0] sum_qch;

  lane_sum_tree #(.LANES(LANES), .SAMPLE_W(SAMPLE_W), .SUM_W(SUM_W)) u_sum_i (
    .clk_i   (clk100),
    .rst_i   (reset),
    .lanes_i (data_i),
    .sum_o   (sum_ich)
  );

  lane_sum_tree #(.LANES(LANES), .SAMPLE_W(SAMPLE_W), .SUM_W(SUM_W)) u_sum_q (
    .clk_i   (clk100),
    .rst_i   (reset),
    .lanes_i (data_q),
    .sum_o   (sum_qch)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    skip_d    = skip_q;
    len_d     = len_q;
    shift_d   = shift_q;
    drain_d   = 1'b0;
    add_d     = 1'b0;
    acci_d    = acci_q;
    accq_d    = accq_q;
    win_sat_d = win_sat_q;
    i_val_d   = i_val_q;
    q_val_d   = q_val_q;
    sat_d     = sat_q;

    // Lane sums registered last cycle are folded in one edge later.
    if (add_q) begin
      acci_d    = ACC_W'(sat_add(SAT_W'(acci_q), SAT_W'(sum_ich), ACC_W));
      accq_d    = ACC_W'(sat_add(SAT_W'(accq_q), SAT_W'(sum_qch), ACC_W));
      win_sat_d = win_sat_q
                | sat_ovf(SAT_W'(acci_q), SAT_W'(sum_ich), ACC_W)
                | sat_ovf(SAT_W'(accq_q), SAT_W'(sum_qch), ACC_W);
    end

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          skip_d    = skip_cycles;
          len_d     = sample_length;
          shift_d   = out_shift;
          cnt_d     = '0;
          acci_d    = '0;
          accq_d    = '0;
          win_sat_d = 1'b0;
          if (skip_cycles != '0) begin
            state_d = SKIP;
          end else if (sample_length != '0) begin
            state_d = ACCUM;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      SKIP: begin
        if (data_valid) begin
          if (cnt_q == skip_q - LEN_W'(1)) begin
            cnt_d   = '0;
            state_d = (len_q != '0) ? ACCUM : DRAIN;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      ACCUM: begin
        if (data_valid) begin
          add_d = 1'b1;
          if (cnt_q == len_q - LEN_W'(1)) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = HOLD;
          i_val_d = acci_q >>> shift_q;
          q_val_d = accq_q >>> shift_q;
          sat_d   = win_sat_q;
        end else begin
          drain_d = 1'b1;
        end
      end
      HOLD: begin
        if (iq_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort drops the window without touching the last delivered result.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      add_d   = 1'b0;
      drain_d = 1'b0;
      i_val_d = i_val_q;
      q_val_d = q_val_q;
      sat_d   = sat_q;
    end

    busy_d  = (state_d != IDLE);
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      skip_q    <= '0;
      len_q     <= '0;
      shift_q   <= '0;
      drain_q   <= 1'b0;
      add_q     <= 1'b0;
      acci_q    <= '0;
      accq_q    <= '0;
      win_sat_q <= 1'b0;
      i_val_q   <= '0;
      q_val_q   <= '0;
      sat_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      skip_q    <= skip_d;
      len_q     <= len_d;
      shift_q   <= shift_d;
      drain_q   <= drain_d;
      add_q     <= add_d;
      acci_q    <= acci_d;
      accq_q    <= accq_d;
      win_sat_q <= win_sat_d;
      i_val_q   <= i_val_d;
      q_val_q   <= q_val_d;
      sat_q     <= sat_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign busy     = busy_q;
  assign iq_valid = valid_q;
  assign i_val    = i_val_q;
  assign q_val    = q_val_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_iq_window_integrator.sv
// Randomised and directed bench for iq_window_integrator against a plain-arithmetic window model.
module tb_iq_window_integrator;

  localparam int LANES = 5;
  localparam int SW    = 16;
  localparam int LW    = LANES * SW;
  localparam int LEN_W = 11;

  logic clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  logic             reset, start, abort, data_valid, iq_ready;
  logic [LEN_W-1:0] skip_cycles, sample_length;
  logic [4:0]       out_shift;
  logic [LW-1:0]    data_i, data_q;
  logic             busy, iq_valid, sat;
  logic             busy_s, iq_valid_s, sat_s;
  logic signed [31:0] i_val, q_val;
  logic signed [19:0] i_val_s, q_val_s;

  iq_window_integrator #(.LANES(5), .SAMPLE_W(16), .ACC_W(32), .LEN_W(11)) dut (
    .clk100(clk100), .reset(reset), .start(start), .abort(abort),
    .skip_cycles(skip_cycles), .sample_length(sample_length), .out_shift(out_shift),
    .data_valid(data_valid), .data_i(data_i), .data_q(data_q),
    .busy(busy), .iq_valid(iq_valid), .iq_ready(iq_ready),
    .i_val(i_val), .q_val(q_val), .sat(sat)
  );

  iq_window_integrator #(.LANES(5), .SAMPLE_W(16), .ACC_W(20), .LEN_W(11)) dut_s (
    .clk100(clk100), .reset(reset), .start(start), .abort(abort),
    .skip_cycles(skip_cycles), .sample_length(sample_length), .out_shift(out_shift),
    .data_valid(data_valid), .data_i(data_i), .data_q(data_q),
    .busy(busy_s), .iq_valid(iq_valid_s), .iq_ready(iq_ready),
    .i_val(i_val_s), .q_val(q_val_s), .sat(sat_s)
  );

  logic [LW-1:0] bi_q[$];
  logic [LW-1:0] bq_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  function automatic logic [LW-1:0] lanes_of(input int base, input int step);
    logic [LW-1:0] b;
    b = '0;
    for (int l = 0; l < LANES; l++) b[l*SW +: SW] = SW'(base + step * l);
    return b;
  endfunction

  function automatic longint beat_total(input logic [LW-1:0] b);
    longint s;
    logic signed [SW-1:0] v;
    s = 0;
    for (int l = 0; l < LANES; l++) begin
      v = b[l*SW +: SW];
      s += longint'(v);
    end
    return s;
  endfunction

  // Window result: sum beats skip..skip+len-1 with clamping to w bits, then shift.
  function automatic longint model_res(input bit use_q, input int skip, input int len,
                                       input int w, input int shift, output bit s);
    longint acc, hi, lo;
    acc = 0;
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -hi - 1;
    s   = 1'b0;
    for (int n = skip; n < skip + len; n++) begin
      acc += beat_total(use_q ? bq_q[n] : bi_q[n]);
      if (acc > hi) begin acc = hi; s = 1'b1; end
      else if (acc < lo) begin acc = lo; s = 1'b1; end
    end
    return acc >>> shift;
  endfunction

  // Start a window, feed the queued beats, and return edges from last beat to iq_valid.
  task automatic run_window(input int skip, input int len, input int shift,
                            input int gap_mode, output int lat);
    int gaps;
    skip_cycles   = LEN_W'(skip);
    sample_length = LEN_W'(len);
    out_shift     = 5'(shift);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < skip + len; n++) begin
      gaps = 0;
      if (gap_mode == 1 && n > 0) gaps = 1;
      if (gap_mode == 2) gaps = int'($urandom_range(0, 2));
      repeat (gaps) begin
        data_valid = 1'b0;
        data_i = LW'({$urandom(), $urandom(), $urandom()});
        data_q = LW'({$urandom(), $urandom(), $urandom()});
        tick();
      end
      data_valid = 1'b1;
      data_i = bi_q[n];
      data_q = bq_q[n];
      tick();
    end
    data_valid = 1'b0;
    lat = 0;
    while (iq_valid !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    if (iq_valid !== 1'b1) lat = -1;
  endtask

  task automatic release_result();
    iq_ready = 1'b1;
    tick();
    iq_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; data_valid = 1'b0; iq_ready = 1'b0;
    skip_cycles = '0; sample_length = '0; out_shift = '0; data_i = '0; data_q = '0;
    repeat (3) tick();
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (iq_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", iq_valid); else n_pass++;
    n_checks++; if (i_val !== 0) $display("FAIL reset_i got %0d exp 0", i_val); else n_pass++;
    n_checks++; if (q_val !== 0) $display("FAIL reset_q got %0d exp 0", q_val); else n_pass++;
    n_checks++; if (sat !== 1'b0) $display("FAIL reset_sat got %b exp 0", sat); else n_pass++;
  endtask

  task automatic test_ramp();
    int lat;
    bi_q.delete(); bq_q.delete();
    for (int n = 0; n < 2000; n++) begin bi_q.push_back(lanes_of(0, 1)); bq_q.push_back(lanes_of(0, 1)); end
    run_window(0, 2000, 0, 0, lat);
    n_checks++; if (i_val !== 20000) $display("FAIL ramp_i got %0d exp 20000", i_val); else n_pass++;
    n_checks++; if (q_val !== 20000) $display("FAIL ramp_q got %0d exp 20000", q_val); else n_pass++;
    n_checks++; if (sat !== 1'b0) $display("FAIL ramp_sat got %b exp 0", sat); else n_pass++;
    n_checks++; if (lat !== 2) $display("FAIL ramp_latency got %0d exp 2", lat); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL ramp_busy_hold got %b exp 1", busy); else n_pass++;
    release_result();
    n_checks++; if (iq_valid !== 1'b0) $display("FAIL ramp_valid_drop got %b exp 0", iq_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL ramp_idle got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_skip();
    int lat;
    bi_q.delete(); bq_q.delete();
    for (int n = 0; n < 7; n++) begin bi_q.push_back(lanes_of(n, 0)); bq_q.push_back(lanes_of(-n, 0)); end
    run_window(3, 4, 0, 0, lat);
    n_checks++; if (i_val !== 90) $display("FAIL skip_i got %0d exp 90", i_val); else n_pass++;
    n_checks++; if (q_val !== -90) $display("FAIL skip_q got %0d exp -90", q_val); else n_pass++;
    n_checks++; if (lat !== 2) $display("FAIL skip_latency got %0d exp 2", lat); else n_pass++;
    release_result();
  endtask

  task automatic test_saturation();
    int lat;
    bi_q.delete(); bq_q.delete();
    for (int n = 0; n < 10; n++) begin bi_q.push_back(lanes_of(32767, 0)); bq_q.push_back(lanes_of(-32768, 0)); end
    run_window(0, 10, 0, 0, lat);
    n_checks++; if (i_val_s !== 524287) $display("FAIL sat20_i got %0d exp 524287", i_val_s); else n_pass++;
    n_checks++; if (q_val_s !== -524288) $display("FAIL sat20_q got %0d exp -524288", q_val_s); else n_pass++;
    n_checks++; if (sat_s !== 1'b1) $display("FAIL sat20_flag got %b exp 1", sat_s); else n_pass++;
    n_checks++; if (i_val !== 1638350) $display("FAIL sat32_i got %0d exp 1638350", i_val); else n_pass++;
    n_checks++; if (q_val !== -1638400) $display("FAIL sat32_q got %0d exp -1638400", q_val); else n_pass++;
    n_checks++; if (sat !== 1'b0) $display("FAIL sat32_flag got %b exp 0", sat); else n_pass++;
    release_result();
  endtask

  task automatic test_reset_mid();
    bi_q.delete(); bq_q.delete();
    skip_cycles = '0; sample_length = LEN_W'(10); out_shift = '0;
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 4; n++) begin data_valid = 1'b1; data_i = lanes_of(100, 1); data_q = lanes_of(-7, 0); tick(); end
    data_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (iq_valid !== 1'b0) $display("FAIL rstmid_valid got %b exp 0", iq_valid); else n_pass++;
    n_checks++; if (i_val !== 0) $display("FAIL rstmid_i got %0d exp 0", i_val); else n_pass++;
    n_checks++; if (q_val !== 0) $display("FAIL rstmid_q got %0d exp 0", q_val); else n_pass++;
    n_checks++; if (sat_s !== 1'b0) $display("FAIL rstmid_sat got %b exp 0", sat_s); else n_pass++;
    repeat (5) tick();
    n_checks++; if (iq_valid !== 1'b0) $display("FAIL rstmid_no_result got %b exp 0", iq_valid); else n_pass++;
  endtask

  task automatic test_gaps();
    int lat;
    bi_q.delete(); bq_q.delete();
    for (int n = 0; n < 4; n++) begin bi_q.push_back(lanes_of(1, 0)); bq_q.push_back(lanes_of(2, 0)); end
    run_window(0, 4, 0, 1, lat);
    n_checks++; if (i_val !== 20) $display("FAIL gaps_i got %0d exp 20", i_val); else n_pass++;
    n_checks++; if (q_val !== 40) $display("FAIL gaps_q got %0d exp 40", q_val); else n_pass++;
    n_checks++; if (lat !== 2) $display("FAIL gaps_latency got %0d exp 2", lat); else n_pass++;
    release_result();
  endtask

  task automatic test_hold();
    int lat;
    bit hold_ok;
    bi_q.delete(); bq_q.delete();
    for (int n = 0; n < 8; n++) begin bi_q.push_back(lanes_of(-1, 0)); bq_q.push_back(lanes_of(7, 0)); end
    run_window(0, 8, 3, 0, lat);
    n_checks++; if (i_val !== -5) $display("FAIL hold_i got %0d exp -5", i_val); else n_pass++;
    n_checks++; if (q_val !== 35) $display("FAIL hold_q got %0d exp 35", q_val); else n_pass++;
    n_checks++; if (lat !== 2) $display("FAIL hold_latency got %0d exp 2", lat); else n_pass++;
    hold_ok = 1'b1;
    sample_length = LEN_W'(5);
    for (int c = 0; c < 10; c++) begin
      start = 1'(c % 2);
      tick();
      if (iq_valid !== 1'b1 || i_val !== -5 || q_val !== 35) hold_ok = 1'b0;
    end
    start = 1'b0;
    n_checks++; if (hold_ok !== 1'b1) $display("FAIL hold_stable got %b exp 1", hold_ok); else n_pass++;
    iq_ready = 1'b1; start = 1'b1;
    tick();
    iq_ready = 1'b0; start = 1'b0;
    n_checks++; if (iq_valid !== 1'b0) $display("FAIL hold_release got %b exp 0", iq_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL hold_start_ignored got %b exp 0", busy); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL hold_still_idle got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_abort();
    int lat;
    bit s_i, s_q;
    longint ei, eq;
    skip_cycles = '0; sample_length = LEN_W'(20); out_shift = '0;
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      data_valid = 1'b1; data_i = LW'({$urandom(), $urandom(), $urandom()}); data_q = LW'({$urandom(), $urandom(), $urandom()}); tick();
    end
    data_valid = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (i_val !== -5) $display("FAIL abort_i_kept got %0d exp -5", i_val); else n_pass++;
    repeat (6) tick();
    n_checks++; if (iq_valid !== 1'b0) $display("FAIL abort_no_result got %b exp 0", iq_valid); else n_pass++;
    abort = 1'b1; start = 1'b1; sample_length = LEN_W'(3);
    tick();
    abort = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_beats_start got %b exp 0", busy); else n_pass++;
    bi_q.delete(); bq_q.delete();
    for (int n = 0; n < 2; n++) begin
      bi_q.push_back(LW'({$urandom(), $urandom(), $urandom()}));
      bq_q.push_back(LW'({$urandom(), $urandom(), $urandom()}));
    end
    ei = model_res(1'b0, 0, 2, 32, 0, s_i);
    eq = model_res(1'b1, 0, 2, 32, 0, s_q);
    run_window(0, 2, 0, 0, lat);
    n_checks++; if (longint'(i_val) !== ei) $display("FAIL abort_next_i got %0d exp %0d", i_val, ei); else n_pass++;
    n_checks++; if (longint'(q_val) !== eq) $display("FAIL abort_next_q got %0d exp %0d", q_val, eq); else n_pass++;
    n_checks++; if (lat !== 2) $display("FAIL abort_next_latency got %0d exp 2", lat); else n_pass++;
    release_result();
  endtask

  task automatic test_random();
    int lat, skip, len, shift, gap, mode;
    bit s_i, s_q, s20_i, s20_q;
    longint ei, eq, ei20, eq20;
    for (int w = 0; w < 12; w++) begin
      skip  = int'($urandom_range(0, 4));
      len   = int'($urandom_range(0, 40));
      shift = int'($urandom_range(0, 6));
      gap   = int'($urandom_range(0, 2));
      mode  = int'($urandom_range(0, 1));
      bi_q.delete(); bq_q.delete();
      for (int n = 0; n < skip + len; n++) begin
        if (mode == 0) begin
          bi_q.push_back(LW'({$urandom(), $urandom(), $urandom()}));
          bq_q.push_back(LW'({$urandom(), $urandom(), $urandom()}));
        end else begin
          bi_q.push_back(lanes_of(int'($urandom_range(20000, 32000)), int'($urandom_range(0, 100))));
          bq_q.push_back(lanes_of(-int'($urandom_range(20000, 32000)), -int'($urandom_range(0, 100))));
        end
      end
      ei   = model_res(1'b0, skip, len, 32, shift, s_i);
      eq   = model_res(1'b1, skip, len, 32, shift, s_q);
      ei20 = model_res(1'b0, skip, len, 20, shift, s20_i);
      eq20 = model_res(1'b1, skip, len, 20, shift, s20_q);
      run_window(skip, len, shift, gap, lat);
      n_checks++; if (longint'(i_val) !== ei) $display("FAIL rnd%0d_i got %0d exp %0d", w, i_val, ei); else n_pass++;
      n_checks++; if (longint'(q_val) !== eq) $display("FAIL rnd%0d_q got %0d exp %0d", w, q_val, eq); else n_pass++;
      n_checks++; if (sat !== (s_i | s_q)) $display("FAIL rnd%0d_sat got %b exp %b", w, sat, s_i | s_q); else n_pass++;
      n_checks++; if (longint'(i_val_s) !== ei20) $display("FAIL rnd%0d_i20 got %0d exp %0d", w, i_val_s, ei20); else n_pass++;
      n_checks++; if (longint'(q_val_s) !== eq20) $display("FAIL rnd%0d_q20 got %0d exp %0d", w, q_val_s, eq20); else n_pass++;
      n_checks++; if (sat_s !== (s20_i | s20_q)) $display("FAIL rnd%0d_sat20 got %b exp %b", w, sat_s, s20_i | s20_q); else n_pass++;
      n_checks++; if (lat !== 2) $display("FAIL rnd%0d_latency got %0d exp 2", w, lat); else n_pass++;
      release_result();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp();
    test_skip();
    test_saturation();
    test_reset_mid();
    test_gaps();
    test_hold();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
